// File: rtl/mv_array_reader_if.sv
// MV output stream bundle for mv_array_reader: valid/ready handshake with data, position and flags.
interface mv_array_reader_if #(
  parameter int unsigned MVW = 12
) ();
  logic           mv_valid;
  logic           mv_ready;
  logic [MVW-1:0] mv_data;
  logic [13:0]    mv_pos;
  logic           mv_rowend;
  logic           mv_frameend;

  modport master (
    output mv_valid,
    output mv_data,
    output mv_pos,
    output mv_rowend,
    output mv_frameend,
    input  mv_ready
  );

  modport slave (
    input  mv_valid,
    input  mv_data,
    input  mv_pos,
    input  mv_rowend,
    input  mv_frameend,
    output mv_ready
  );
endinterface

// File: rtl/mv_array_reader.sv
// Frame readout of the MV array: raster-order scan with reads to a 1-cycle-latency sync RAM.
// Motion vectors stream out through a 2-entry buffer, which keeps backpressure lossless at 1 MV/cycle.
// Optional feature macro: MVRD_CHECKSUM_EN adds a 16-bit rotate/XOR checksum of the streamed words.
module mv_array_reader #(
  parameter int unsigned totalblockX = 79,
  parameter int unsigned totalblockY = 44,
  parameter int unsigned MVW         = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             MVArray_RE,
  output logic [13:0]      MVArray_RAddr,
  input  logic [MVW-1:0]   MVArray_RData,
`ifdef MVRD_CHECKSUM_EN
  output logic [15:0]      mv_checksum,
`endif
  mv_array_reader_if.master mv
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [6:0] LastX = 7'(totalblockX);
  localparam logic [6:0] LastY = 7'(totalblockY);

  logic [1:0]     state_q, state_d;
  logic [6:0]     x_q, y_q;
  logic           inflight_q;
  logic [13:0]    inflight_pos_q;
  logic [1:0]     occ_q, occ_d, occ_after;
  logic [MVW-1:0] s0_data_q, s0_data_d, s1_data_q, s1_data_d;
  logic [13:0]    s0_pos_q, s0_pos_d, s1_pos_q, s1_pos_d;

  logic           pop, push, re, last_addr, start_acc;
  logic [2:0]     level;

  assign pop       = mv.mv_valid && mv.mv_ready;
  assign push      = inflight_q;
  assign start_acc = (state_q == StIdle) && start;
  assign last_addr = (x_q == LastX) && (y_q == LastY);

  // Slots committed after this edge: buffered plus in flight, minus the one leaving now.
  assign level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign re    = (state_q == StRead) && (level < 3'd2);

  assign MVArray_RE    = re;
  assign MVArray_RAddr = {y_q, x_q};

  assign busy = (state_q == StRead) || (state_q == StDrain);
  assign done = (state_q == StDone);

  // Head entry drives the stream; flags come from its own position tag.
  assign mv.mv_valid    = (occ_q != 2'd0);
  assign mv.mv_data     = s0_data_q;
  assign mv.mv_pos      = s0_pos_q;
  assign mv.mv_rowend   = mv.mv_valid && (s0_pos_q[6:0] == LastX);
  assign mv.mv_frameend = mv.mv_valid && (s0_pos_q == {LastY, LastX});

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (re && last_addr) state_d = StDrain;
      StDrain: if (pop && mv.mv_frameend) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Buffer update: a pop frees the head before a returning word is placed.
  always_comb begin
    s0_data_d = s0_data_q;
    s0_pos_d  = s0_pos_q;
    s1_data_d = s1_data_q;
    s1_pos_d  = s1_pos_q;
    occ_after = occ_q - 2'(pop);
    if (pop) begin
      s0_data_d = s1_data_q;
      s0_pos_d  = s1_pos_q;
    end
    if (push) begin
      if (occ_after == 2'd0) begin
        s0_data_d = MVArray_RData;
        s0_pos_d  = inflight_pos_q;
      end else begin
        s1_data_d = MVArray_RData;
        s1_pos_d  = inflight_pos_q;
      end
    end
    occ_d = occ_after + 2'(push);
  end

  // State, scan counters, in-flight tag and buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      x_q            <= '0;
      y_q            <= '0;
      inflight_q     <= 1'b0;
      inflight_pos_q <= '0;
      occ_q          <= '0;
      s0_data_q      <= '0;
      s0_pos_q       <= '0;
      s1_data_q      <= '0;
      s1_pos_q       <= '0;
    end else begin
      state_q        <= state_d;
      inflight_q     <= re;
      inflight_pos_q <= {y_q, x_q};
      occ_q          <= occ_d;
      s0_data_q      <= s0_data_d;
      s0_pos_q       <= s0_pos_d;
      s1_data_q      <= s1_data_d;
      s1_pos_q       <= s1_pos_d;
      if (start_acc) begin
        x_q <= '0;
        y_q <= '0;
      end else if (re && !last_addr) begin
        // Counter parks on the last address once it has been issued.
        if (x_q == LastX) begin
          x_q <= '0;
          y_q <= y_q + 7'd1;
        end else begin
          x_q <= x_q + 7'd1;
        end
      end
    end
  end

  // A returning word must always find a free slot.
  buffer_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (occ_after == 2'd2)));

`ifdef MVRD_CHECKSUM_EN
  logic [15:0]     checksum_q;
  logic [MVW+15:0] data_ext;

  assign data_ext    = {16'b0, mv.mv_data};
  assign mv_checksum = checksum_q;

  // Rotate-left-by-1 then XOR of each handshaken word; cleared when a frame starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= {checksum_q[14:0], checksum_q[15]} ^ data_ext[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_mv_array_reader.sv
// Directed-plus-random bench for mv_array_reader on a 4x2 block frame.
// Built with or without MVRD_CHECKSUM_EN; the checksum checks follow the macro.
module tb_mv_array_reader;
  localparam int unsigned TBX  = 3;
  localparam int unsigned TBY  = 1;
  localparam int unsigned W    = 12;
  localparam int          NMV  = (TBX + 1) * (TBY + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          re;
  logic [13:0]   raddr;
  logic [W-1:0]  rdata;
`ifdef MVRD_CHECKSUM_EN
  logic [15:0]   cs;
`endif

  mv_array_reader_if #(.MVW(W)) mv_if ();

  mv_array_reader #(
    .totalblockX(TBX),
    .totalblockY(TBY),
    .MVW(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .MVArray_RE(re),
    .MVArray_RAddr(raddr),
    .MVArray_RData(rdata),
`ifdef MVRD_CHECKSUM_EN
    .mv_checksum(cs),
`endif
    .mv(mv_if.master)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:16383];

  // Sync RAM with one cycle of read latency.
  always @(posedge clk) if (re) rdata <= mem[raddr];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc_n = 0;
  int          outstanding, first_valid, done_at, done_cnt, re_cnt, hs_cnt;
  logic [13:0] exp_q[$];
  logic [13:0] rd_q[$];
  logic        prev_stall;
  logic [W-1:0] prev_data;
  logic [13:0] prev_pos;
  logic        last_busy, last_done, last_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [13:0] raster_pos(input int n);
    int y, x;
    y = n / (TBX + 1);
    x = n % (TBX + 1);
    return {7'(y), 7'(x)};
  endfunction

  function automatic logic [15:0] fold_ref();
    logic [15:0] c;
    c = '0;
    for (int n = 0; n < NMV; n++) c = {c[14:0], c[15]} ^ 16'(mem[raster_pos(n)]);
    return c;
  endfunction

  task automatic new_frame();
    exp_q.delete();
    rd_q.delete();
    for (int n = 0; n < NMV; n++) begin
      exp_q.push_back(raster_pos(n));
      rd_q.push_back(raster_pos(n));
    end
    outstanding = 0;
    first_valid = -1;
    done_at     = -1;
    done_cnt    = 0;
    re_cnt      = 0;
    hs_cnt      = 0;
    prev_stall  = 1'b0;
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, check against the model, advance.
  task automatic cyc(input logic rdy, input logic st);
    logic        hs;
    logic [13:0] e;
    mv_if.mv_ready = rdy;
    start = st;
    #3;
    hs = mv_if.mv_valid && rdy;
    if (re) begin
      re_cnt++;
      check("re_window", 32'(outstanding - int'(hs) < 2), 32'd1);
      if (rd_q.size() == 0) check("read_left", 32'(rd_q.size()), 32'd1);
      else begin
        e = rd_q.pop_front();
        check("raddr", 32'(raddr), 32'(e));
      end
    end
    if (prev_stall) begin
      check("hold_valid", 32'(mv_if.mv_valid), 32'd1);
      check("hold_data", 32'(mv_if.mv_data), 32'(prev_data));
      check("hold_pos", 32'(mv_if.mv_pos), 32'(prev_pos));
    end
    if (hs) begin
      hs_cnt++;
      if (exp_q.size() == 0) check("mv_left", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("mv_pos", 32'(mv_if.mv_pos), 32'(e));
        check("mv_data", 32'(mv_if.mv_data), 32'(mem[e]));
        check("rowend", 32'(mv_if.mv_rowend), 32'(e[6:0] == 7'(TBX)));
        check("frameend", 32'(mv_if.mv_frameend), 32'(e == {7'(TBY), 7'(TBX)}));
      end
    end
    if (mv_if.mv_valid && first_valid < 0) first_valid = cyc_n;
    if (done) begin
      done_cnt++;
      done_at = cyc_n;
    end
    last_busy   = busy;
    last_done   = done;
    last_valid  = mv_if.mv_valid;
    outstanding = outstanding + int'(re) - int'(hs);
    prev_stall  = mv_if.mv_valid && !rdy;
    prev_data   = mv_if.mv_data;
    prev_pos    = mv_if.mv_pos;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run_to_done(input bit rnd);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      check("busy", 32'(last_busy), 32'(!last_done));
    end
    check("done_seen", 32'(done_cnt), 32'd1);
  endtask

  task automatic frame_totals(input string tag);
    check({tag, "_mv_count"}, 32'(hs_cnt), 32'(NMV));
    check({tag, "_re_count"}, 32'(re_cnt), 32'(NMV));
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(mv_if.mv_valid), 32'd0);
    check({tag, "_re"}, 32'(re), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_raddr"}, 32'(raddr), 32'd0);
    check({tag, "_pos"}, 32'(mv_if.mv_pos), 32'd0);
    check({tag, "_data"}, 32'(mv_if.mv_data), 32'd0);
    check({tag, "_rowend"}, 32'(mv_if.mv_rowend), 32'd0);
    check({tag, "_frameend"}, 32'(mv_if.mv_frameend), 32'd0);
`ifdef MVRD_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(cs), 32'd0);
`endif
  endtask

  task automatic check_checksum_hold(input string tag);
`ifdef MVRD_CHECKSUM_EN
    repeat (3) cyc(1'b1, 1'b0);
    check(tag, 32'(cs), 32'(fold_ref()));
`else
    repeat (3) cyc(1'b1, 1'b0);
    check(tag, 32'(busy), 32'd0);
`endif
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    start = 1'b0;
    mv_if.mv_ready = 1'b0;
    for (int a = 0; a < 16384; a++) mem[a] = 12'(a);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Test 1: ready held high, data = address.
    new_frame();
    c0 = cyc_n;
    cyc(1'b1, 1'b1);
    run_to_done(1'b0);
    frame_totals("t1");
    check("t1_first_valid", 32'(first_valid - c0), 32'd3);
    check("t1_done_at", 32'(done_at - c0), 32'd11);
    check_checksum_hold("t1_checksum");
    check("t1_one_done", 32'(done_cnt), 32'd1);

    // Test 2: random RAM contents and random backpressure.
    for (int a = 0; a < 16384; a++) mem[a] = 12'($urandom);
    new_frame();
    cyc(1'b1, 1'b1);
    run_to_done(1'b1);
    frame_totals("t2");
    check_checksum_hold("t2_checksum");

    // Test 3: consumer stalled for 10 cycles after start.
    new_frame();
    cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    check("t3_re_pulses", 32'(re_cnt), 32'd2);
    check("t3_valid", 32'(mv_if.mv_valid), 32'd1);
    check("t3_pos", 32'(mv_if.mv_pos), 32'd0);
    run_to_done(1'b0);
    frame_totals("t3");

    // Test 4: start re-pulsed during READ and in the DONE cycle.
    new_frame();
    c0 = cyc_n;
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b1);
    for (int i = 0; i < 22; i++) cyc(1'b1, 1'(cyc_n == c0 + 11));
    check("t4_done_at", 32'(done_at - c0), 32'd11);
    check("t4_one_done", 32'(done_cnt), 32'd1);
    check("t4_idle", 32'(last_busy), 32'd0);
    frame_totals("t4");

    // Test 5: reset while draining with valid data held.
    new_frame();
    cyc(1'b1, 1'b1);
    repeat (8) cyc(1'b1, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    check("t5_busy_pre", 32'(last_busy), 32'd1);
    check("t5_valid_pre", 32'(last_valid), 32'd1);
    check_zero("t5_reset");
    reset = 1'b0;
    new_frame();
    c0 = cyc_n;
    cyc(1'b1, 1'b1);
    run_to_done(1'b0);
    frame_totals("t5");
    check("t5_first_valid", 32'(first_valid - c0), 32'd3);
    check("t5_done_at", 32'(done_at - c0), 32'd11);
    check_checksum_hold("t5_checksum");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
